stream_thread_pack: RTL
=======================

Name: stream_thread_pack

Overview:
- Packs a single-lane feature stream (WIDTH bits/sample) into THREAD-lane words (WIDTH*THREAD bits).
- Input and output use the vsync/hsync/valid stream protocol.
- Sits between a single-lane layer output (e.g. a pooling/reshape stage) and the next THREAD-lane layer or line FIFO.
- Repacks samples in arrival order, zero-pads a short final word at line end, flags line-length mismatches.

Parameters:
- WIDTH, 27, bits per sample.
- THREAD, 2, lanes per output word (>=2).
- SIZE, 56, pixels per line.
- CHANNEL, 32, channels per pixel; expected samples per line = SIZE*CHANNEL.

Ports:
- i_sclk  in  1  clock, all logic on rising edge.
- i_rst  in  1  asynchronous active-high reset.
- i_vsync  in  1  high = between frames; synchronously clears packing state.
- i_hsync  in  1  high for the duration of an active line.
- i_valid  in  1  qualifies i_tdata; ignored unless i_hsync=1 and i_vsync=0.
- i_tdata  in  WIDTH  sample.
- o_vsync  out  1  i_vsync delayed 1 cycle.
- o_hsync  out  1  i_hsync delayed 1 cycle, extended 1 cycle when a flush word is emitted.
- o_valid  out  1  one-cycle pulse per packed word.
- o_tdata  out  WIDTH*THREAD  packed word; lane k at bits [WIDTH*(k+1)-1 : WIDTH*k].
- o_last  out  1  with o_valid, marks the word holding the line's final expected sample.
- o_err  out  1  sticky line-length error.

Behaviour:
- Reset (i_rst=1, async): all outputs 0; lane counter, sample counter, shift register and hsync history cleared.
- Accepted sample: i_valid & i_hsync & ~i_vsync. Written into lane lane_cnt; lane_cnt increments.
- Lane 0 is the first sample in time (lowest bits).
- Word complete: lane_cnt reaches THREAD-1 on an accepted sample.
  - Next cycle: o_valid=1 and o_tdata = assembled word. Latency is 1 cycle from the completing sample.
  - lane_cnt wraps to 0.
- Sample counter: 0..SIZE*CHANNEL-1, increments per accepted sample.
  - o_last=1 on the word containing sample index SIZE*CHANNEL-1.
  - The counter saturates there; any further samples in the same line set o_err (overflow) and are still packed.
- Line end: falling edge of i_hsync (hsync_d1=1, i_hsync=0).
  - If lane_cnt != 0: the next cycle is a flush. o_valid=1, unfilled upper lanes = 0, o_hsync held 1 for that cycle, lane_cnt reset to 0.
  - o_last follows the counter rule, so it is 0 on an underfull line.
  - The sample counter resets to 0 at every falling edge.
  - If count != SIZE*CHANNEL at the falling edge: o_err set (underflow).
- Simultaneous events:
  - Sample arriving in the same cycle hsync falls: not accepted (hsync=0).
  - Word completing on the last sample with hsync falling next cycle: normal word only, no flush.
  - Back-to-back lines (hsync low for 1 cycle): a flush and a new line's first sample do not collide, because output occurs 1 cycle after acceptance.
- i_vsync=1:
  - Synchronously clears lane_cnt, sample counter and any partial word, with no flush.
  - o_valid forced 0 the cycle after.
  - o_err cleared on the i_vsync rising edge.
- Reset asserted mid-line: partial word is discarded; no output until a new hsync rising edge after release.
- Stalls: data must be held through stalls by the upstream; no backpressure port.
- Arithmetic: counters sized $clog2(SIZE*CHANNEL+1) and $clog2(THREAD); no data arithmetic, bit-exact passthrough.

Optional Feature:
- Macro: STREAM_THREAD_PACK_LENCHK_EN.
- Defined: sample counter, o_last and o_err behave as specified.
- Undefined:
  - Counter logic omitted; o_last and o_err tied 0.
  - Flush-at-line-end still operates, driven only by lane_cnt.

Test Plan (WIDTH=27, THREAD=2, SIZE=2, CHANNEL=3, i.e. 6 samples/line):
1. Reset with i_rst pulse mid-stream -> all outputs 0 asynchronously; after release with i_vsync=1, no o_valid.
2. One line, 6 consecutive samples 1..6 -> three o_valid pulses, 1 cycle after samples 2/4/6, o_tdata = {2,1},{4,3},{6,5}; o_last only on {6,5}; o_err=0.
3. Line of 5 samples 1..5, then hsync falls -> words {2,1},{4,3}, then flush {0,5} with o_hsync held high; o_last=0; o_err=1 and stays 1 until the next vsync rising edge.
4. Line with samples gapped (i_valid toggling 1,0,1,0...) -> same words as scenario 2, each 1 cycle after the completing sample.
5. Line of 7 samples -> o_last on {6,5}, flush {0,7}, o_err=1.
6. i_vsync asserted after 3 samples -> {2,1} emitted, sample 3 discarded with no flush; next frame's first word = {b,a} from fresh samples.

Source files
------------

// File: rtl/stream_thread_pack.sv
// Packs a single-lane WIDTH-bit sample stream into THREAD-lane words, zero-padding a short final word at line end.
// Define STREAM_THREAD_PACK_LENCHK_EN to enable the per-line sample counter, o_last and o_err.
module stream_thread_pack #(
    parameter int unsigned WIDTH   = 27,
    parameter int unsigned THREAD  = 2,
    parameter int unsigned SIZE    = 56,
    parameter int unsigned CHANNEL = 32
) (
    input  logic                      i_sclk,
    input  logic                      i_rst,
    input  logic                      i_vsync,
    input  logic                      i_hsync,
    input  logic                      i_valid,
    input  logic [WIDTH-1:0]          i_tdata,
    output logic                      o_vsync,
    output logic                      o_hsync,
    output logic                      o_valid,
    output logic [WIDTH*THREAD-1:0]   o_tdata,
    output logic                      o_last,
    output logic                      o_err
);

    localparam int unsigned LW = $clog2(THREAD);

    logic [LW-1:0]           lane_cnt_q, lane_cnt_d;
    logic [WIDTH*THREAD-1:0] shreg_q, shreg_d;
    logic                    hsync_d1_q, hsync_d1_d;
    logic                    armed_q, armed_d;
    logic                    o_vsync_q, o_vsync_d;
    logic                    o_hsync_q, o_hsync_d;
    logic                    o_valid_q, o_valid_d;
    logic [WIDTH*THREAD-1:0] o_tdata_q, o_tdata_d;

    logic                    accept, fall, lane_top, complete, flush, emit;
    logic [WIDTH*THREAD-1:0] word;

    always_comb begin
        // armed_q blocks a line that was already in progress when reset released
        accept   = i_valid & i_hsync & ~i_vsync & armed_q;
        fall     = hsync_d1_q & ~i_hsync & armed_q;
        lane_top = (lane_cnt_q == LW'(THREAD - 1));
        complete = accept & lane_top;
        flush    = fall & ~i_vsync & (lane_cnt_q != '0);
        emit     = complete | flush;

        word = shreg_q;
        for (int unsigned k = 0; k < THREAD; k++) begin
            if (accept && (lane_cnt_q == LW'(k))) begin
                word[k*WIDTH +: WIDTH] = i_tdata;
            end
        end

        lane_cnt_d = lane_cnt_q;
        shreg_d    = word;
        if (accept) begin
            lane_cnt_d = lane_top ? '0 : lane_cnt_q + 1'b1;
        end
        if (emit) begin
            shreg_d = '0;
        end
        if (flush) begin
            lane_cnt_d = '0;
        end
        if (i_vsync) begin
            lane_cnt_d = '0;
            shreg_d    = '0;
        end

        hsync_d1_d = i_hsync;
        armed_d    = armed_q | ~i_hsync;
        o_vsync_d  = i_vsync;
        o_hsync_d  = i_hsync | flush;
        o_valid_d  = emit;
        o_tdata_d  = emit ? word : o_tdata_q;
    end

    always_ff @(posedge i_sclk or posedge i_rst) begin
        if (i_rst) begin
            lane_cnt_q <= '0;
            shreg_q    <= '0;
            hsync_d1_q <= 1'b0;
            armed_q    <= 1'b0;
            o_vsync_q  <= 1'b0;
            o_hsync_q  <= 1'b0;
            o_valid_q  <= 1'b0;
            o_tdata_q  <= '0;
        end else begin
            lane_cnt_q <= lane_cnt_d;
            shreg_q    <= shreg_d;
            hsync_d1_q <= hsync_d1_d;
            armed_q    <= armed_d;
            o_vsync_q  <= o_vsync_d;
            o_hsync_q  <= o_hsync_d;
            o_valid_q  <= o_valid_d;
            o_tdata_q  <= o_tdata_d;
        end
    end

    assign o_vsync = o_vsync_q;
    assign o_hsync = o_hsync_q;
    assign o_valid = o_valid_q;
    assign o_tdata = o_tdata_q;

`ifdef STREAM_THREAD_PACK_LENCHK_EN
    localparam int unsigned NSMP = SIZE * CHANNEL;
    localparam int unsigned CW   = $clog2(NSMP + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          last_pend_q, last_pend_d;
    logic          o_last_q, o_last_d;
    logic          o_err_q, o_err_d;
    logic          last_hit;

    always_comb begin
        // cnt_q saturates at NSMP so that one value flags overflow and a full line
        last_hit    = accept & (cnt_q == CW'(NSMP - 1));
        cnt_d       = cnt_q;
        last_pend_d = last_pend_q;
        o_err_d     = o_err_q;

        if (accept) begin
            if (cnt_q == CW'(NSMP)) begin
                o_err_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        if (last_hit) begin
            last_pend_d = 1'b1;
        end
        o_last_d = emit & (last_pend_q | last_hit);
        if (emit) begin
            last_pend_d = 1'b0;
        end
        if (fall) begin
            cnt_d = '0;
            if (!i_vsync && (cnt_q != CW'(NSMP))) begin
                o_err_d = 1'b1;
            end
        end
        if (i_vsync) begin
            cnt_d       = '0;
            last_pend_d = 1'b0;
        end
        if (i_vsync && !o_vsync_q) begin
            o_err_d = 1'b0;
        end
    end

    always_ff @(posedge i_sclk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q       <= '0;
            last_pend_q <= 1'b0;
            o_last_q    <= 1'b0;
            o_err_q     <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            last_pend_q <= last_pend_d;
            o_last_q    <= o_last_d;
            o_err_q     <= o_err_d;
        end
    end

    assign o_last = o_last_q;
    assign o_err  = o_err_q;
`else
    assign o_last = 1'b0;
    assign o_err  = 1'b0;
`endif

endmodule
